// File: rtl/step_rate_pkg.sv
// Shared state encoding and default profile constants for the step-rate controller.
package step_rate_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    FIN
  } state_t;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_DIV_W     = 16;
  localparam int DEF_START_DIV = 10000;
  localparam int DEF_MIN_DIV   = 1000;
  localparam int DEF_ACC_STEP  = 500;

  // True in the states where the period timer is running.
  function automatic logic isMoving(input state_t s);
    return (s == ACCEL) || (s == CRUISE) || (s == DECEL);
  endfunction

endpackage

// File: rtl/step_period_timer.sv
// Step period counter: counts while enabled and ticks for one cycle when the
// count reaches div-1, then wraps to zero. restart_i forces the count back to zero.
module step_period_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             cr,
  input  logic             restart_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == (div_i - DIV_W'(1)));

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : (cnt_q + DIV_W'(1));
    end
  end

endmodule

// File: rtl/step_rate_ctrl.sv
// Trapezoidal step-rate profile generator feeding the three-phase step motor
// driver: linear ramp up, cruise, symmetric ramp down, with controlled stop.
module step_rate_ctrl
  import step_rate_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_W     = DEF_DIV_W,
  parameter int START_DIV = DEF_START_DIV,
  parameter int MIN_DIV   = DEF_MIN_DIV,
  parameter int ACC_STEP  = DEF_ACC_STEP
) (
  input  logic             clk,
  input  logic             cr,
  input  logic             start,
  input  logic             dir_in,
  input  logic [CNT_W-1:0] steps,
  input  logic             stop,
  output logic             step_clk,
  output logic             M,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam int DW1 = DIV_W + 1;
  localparam int CW1 = CNT_W + 1;
  localparam logic [DIV_W-1:0] START_D = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] ACC_D   = DIV_W'(ACC_STEP);

  state_t           state_q, state_d;
  logic             stepClk_q, m_q, busy_q, done_q, stopLatch_q;
  logic [CNT_W-1:0] stepsLeft_q, stepsLeft_d, rampSteps_q, rampSteps_d, stepsAfter;
  logic [DIV_W-1:0] div_q, div_d, divUp, divDown;
  logic [DW1-1:0]   upSum;
  logic [CW1-1:0]   rampLimit;
  logic             accept, tick, timerEn;

  assign accept  = (state_q == IDLE) && start;
  assign timerEn = busy_q && isMoving(state_q);

  step_period_timer #(
    .DIV_W(DIV_W)
  ) uTimer (
    .clk      (clk),
    .cr       (cr),
    .restart_i(accept),
    .en_i     (timerEn),
    .div_i    (div_q),
    .tick_o   (tick)
  );

  // Profile decision taken at each step boundary; div_q is the period just used.
  // Sums are one bit wider so the clamps never see a wrapped value.
  always_comb begin
    stepsAfter  = stepsLeft_q - CNT_W'(1);
    upSum       = {1'b0, div_q} + DW1'(ACC_STEP);
    divUp       = (upSum >= DW1'(START_DIV)) ? START_D : upSum[DIV_W-1:0];
    divDown     = ({1'b0, div_q} < (DW1'(MIN_DIV) + DW1'(ACC_STEP))) ? MIN_D : (div_q - ACC_D);
    rampLimit   = {1'b0, rampSteps_q} + CW1'(state_q == ACCEL);

    state_d     = state_q;
    div_d       = div_q;
    stepsLeft_d = stepsAfter;
    rampSteps_d = rampSteps_q;

    if (stepsAfter == '0) begin
      state_d = FIN;
    end else if ((state_q != DECEL) && (({1'b0, stepsAfter} <= rampLimit) || stopLatch_q)) begin
      state_d = DECEL;
      div_d   = divUp;
      // A stop trims the move to the steps needed to retrace the ramp.
      if (stopLatch_q && (stepsAfter > rampSteps_q)) begin
        stepsLeft_d = rampSteps_q;
      end
      if (stopLatch_q && (rampSteps_q == '0)) begin
        state_d = FIN;
      end
    end else if (state_q == ACCEL) begin
      div_d       = divDown;
      rampSteps_d = (&rampSteps_q) ? rampSteps_q : (rampSteps_q + CNT_W'(1));
      if (divDown == MIN_D) begin
        state_d = CRUISE;
      end
    end else if (state_q == DECEL) begin
      div_d = divUp;
    end
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      state_q     <= IDLE;
      stepClk_q   <= 1'b0;
      m_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stopLatch_q <= 1'b0;
      stepsLeft_q <= '0;
      rampSteps_q <= '0;
      div_q       <= START_D;
    end else begin
      stepClk_q <= 1'b0;
      done_q    <= 1'b0;
      if (busy_q && (state_q != DECEL) && stop) begin
        stopLatch_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            m_q         <= dir_in;
            stepsLeft_q <= steps;
            div_q       <= START_D;
            rampSteps_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= (steps == '0) ? FIN : ACCEL;
          end
        end
        ACCEL, CRUISE, DECEL: begin
          if (tick) begin
            stepClk_q   <= 1'b1;
            stepsLeft_q <= stepsLeft_d;
            div_q       <= div_d;
            rampSteps_q <= rampSteps_d;
            state_q     <= state_d;
          end
        end
        FIN: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          stopLatch_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign step_clk   = stepClk_q;
  assign M          = m_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = stepsLeft_q;

endmodule

// File: tb/tb_step_rate_ctrl.sv
// Self-checking bench for step_rate_ctrl: directed profile moves plus randomized
// moves compared against a step-by-step arithmetic model of the motion profile.
module tb_step_rate_ctrl;

  localparam int CNT_W     = 16;
  localparam int DIV_W     = 16;
  localparam int START_DIV = 10;
  localparam int MIN_DIV   = 4;
  localparam int ACC_STEP  = 2;

  logic             clk = 1'b0;
  logic             cr;
  logic             start;
  logic             dir_in;
  logic [CNT_W-1:0] steps;
  logic             stop;
  logic             step_clk;
  logic             M;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;

  int compared   = 0;
  int mismatched = 0;
  int expPeriods[$];
  int expLeft[$];
  int lastPulses[$];
  int lastDone;

  always #5 clk = ~clk;

  step_rate_ctrl #(
    .CNT_W    (CNT_W),
    .DIV_W    (DIV_W),
    .START_DIV(START_DIV),
    .MIN_DIV  (MIN_DIV),
    .ACC_STEP (ACC_STEP)
  ) dut (
    .clk       (clk),
    .cr        (cr),
    .start     (start),
    .dir_in    (dir_in),
    .steps     (steps),
    .stop      (stop),
    .step_clk  (step_clk),
    .M         (M),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Walks the move one step at a time with plain integers: the period each
  // step takes and the steps remaining once that step has been issued.
  task automatic buildModel(input int nSteps, input int stopAt);
    int period;
    int ramp;
    int left;
    int k;
    bit decel;
    bit cruise;
    bit stopNow;
    expPeriods = {};
    expLeft    = {};
    period = START_DIV;
    ramp   = 0;
    left   = nSteps;
    k      = 0;
    decel  = 0;
    cruise = 0;
    while (left > 0) begin
      k++;
      expPeriods.push_back(period);
      left--;
      stopNow = (k == stopAt) && !decel;
      if (left > 0) begin
        if (!decel && ((left <= ramp + ((!cruise) ? 1 : 0)) || stopNow)) begin
          if (stopNow && left > ramp) left = ramp;
          decel  = 1;
          period = (period + ACC_STEP > START_DIV) ? START_DIV : period + ACC_STEP;
        end else if (decel) begin
          period = (period + ACC_STEP > START_DIV) ? START_DIV : period + ACC_STEP;
        end else if (!cruise) begin
          period = (period - ACC_STEP < MIN_DIV) ? MIN_DIV : period - ACC_STEP;
          ramp++;
          if (period == MIN_DIV) cruise = 1;
        end
      end
      expLeft.push_back(left);
    end
  endtask

  function automatic int periodOf(input int i);
    if (i >= lastPulses.size()) return -1;
    if (i == 0) return lastPulses[0];
    return lastPulses[i] - lastPulses[i-1];
  endfunction

  // Runs one move from IDLE; pulse times are counted in cycles after the accept edge.
  task automatic applyStimulus(input int nSteps, input logic dirVal, input int stopAt,
                               input int midStartCyc, input bit stopWithStart);
    int expPulse[$];
    int t;
    int expDone;
    int cyc;
    int nObs;
    bit stopSent;
    logic busyPrev;
    buildModel(nSteps, stopAt);
    t = 0;
    expPulse = {};
    foreach (expPeriods[i]) begin
      t += expPeriods[i];
      expPulse.push_back(t);
    end
    expDone    = (expPulse.size() == 0) ? 1 : t + 1;
    lastPulses = {};
    lastDone   = -1;
    cyc        = 0;
    stopSent   = 0;
    @(negedge clk);
    start  = 1'b1;
    dir_in = dirVal;
    steps  = CNT_W'(nSteps);
    stop   = stopWithStart;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("busy_at_accept", busy, 1);
    while (lastDone < 0 && cyc < expDone + 40) begin
      busyPrev = busy;
      @(posedge clk);
      #1;
      cyc++;
      stop   = 1'b0;
      start  = 1'b0;
      dir_in = dirVal;
      if (step_clk === 1'b1) begin
        lastPulses.push_back(cyc);
        nObs = lastPulses.size();
        if (nObs <= expLeft.size())
          checkOutput($sformatf("steps_left_pulse%0d", nObs), steps_left, expLeft[nObs-1]);
      end
      if (done === 1'b1) begin
        lastDone = cyc;
        checkOutput("busy_with_done", busy, 0);
        checkOutput("busy_before_done", busyPrev, 1);
        checkOutput("M_at_done", M, dirVal);
        checkOutput("steps_left_at_done", steps_left, 0);
      end
      if (stopAt > 0 && !stopSent && lastPulses.size() == stopAt - 1) begin
        stop     = 1'b1;
        stopSent = 1;
      end
      if (cyc == midStartCyc) begin
        start  = 1'b1;
        dir_in = ~dirVal;
      end
    end
    checkOutput("pulse_count", lastPulses.size(), expPulse.size());
    for (int i = 0; i < lastPulses.size() && i < expPulse.size(); i++)
      checkOutput($sformatf("pulse_time_%0d", i + 1), lastPulses[i], expPulse[i]);
    checkOutput("done_cycle", lastDone, expDone);
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("done_one_cycle", done, 0);
  endtask

  initial begin
    int p10[10] = '{10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
    int p4[4]   = '{10, 8, 10, 10};
    int n;
    int stopAt;
    int midStart;
    cr     = 1'b0;
    start  = 1'b0;
    dir_in = 1'b0;
    stop   = 1'b0;
    steps  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_step_clk", step_clk, 0);
    checkOutput("reset_M", M, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_steps_left", steps_left, 0);
    @(negedge clk);
    cr = 1'b1;

    $display("[TB] ten-step trapezoid");
    applyStimulus(10, 1'b1, 0, 0, 0);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("p10_period_%0d", i + 1), periodOf(i), p10[i]);
    checkOutput("p10_done_cycle", lastDone, 65);

    $display("[TB] four-step short move");
    applyStimulus(4, 1'b1, 0, 0, 0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("p4_period_%0d", i + 1), periodOf(i), p4[i]);

    $display("[TB] zero-step move");
    applyStimulus(0, 1'b0, 0, 0, 0);
    checkOutput("zero_done_cycle", lastDone, 1);
    checkOutput("zero_pulses", lastPulses.size(), 0);

    $display("[TB] stop during cruise");
    applyStimulus(100, 1'b1, 21, 0, 0);
    checkOutput("stop_pulses", lastPulses.size(), 24);
    checkOutput("stop_period_a", periodOf(21), 6);
    checkOutput("stop_period_b", periodOf(22), 8);
    checkOutput("stop_period_c", periodOf(23), 10);

    $display("[TB] start while busy");
    applyStimulus(10, 1'b1, 0, 25, 0);
    checkOutput("midstart_pulses", lastPulses.size(), 10);

    $display("[TB] reset mid-period");
    @(negedge clk);
    start  = 1'b1;
    dir_in = 1'b1;
    steps  = CNT_W'(10);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    cr = 1'b0;
    #1;
    checkOutput("async_step_clk", step_clk, 0);
    checkOutput("async_M", M, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_done", done, 0);
    checkOutput("async_steps_left", steps_left, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no_pulse_in_reset", step_clk, 0);
    end
    @(negedge clk);
    cr = 1'b1;
    applyStimulus(10, 1'b1, 0, 0, 0);
    checkOutput("first_period_after_reset", periodOf(0), 10);

    $display("[TB] randomized moves");
    for (int r = 0; r < 10; r++) begin
      n        = $urandom_range(0, 30);
      stopAt   = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      midStart = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 8) : 0;
      applyStimulus(n, 1'($urandom_range(0, 1)), stopAt, midStart, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
